// File: rtl/axil_pkg.sv
// Shared response codes, FSM state encodings and latency counter width for the
// AXI4-Lite SRAM responder.
package axil_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_RESP
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_WAIT,
    B_RESP
  } wr_state_t;

  localparam int unsigned LAT_W = 4;

endpackage

// File: rtl/axil_sram_mem.sv
// Word-organised SRAM: one synchronous read port, one byte-masked synchronous
// write port; a same-word read and write on one edge returns the old word.
module axil_sram_mem #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic                    clk_i,
  input  logic                    rd_en_i,
  input  logic [IDX_W-1:0]        rd_idx_i,
  output logic [DATA_WIDTH-1:0]   rd_data_o,
  input  logic                    wr_en_i,
  input  logic [IDX_W-1:0]        wr_idx_i,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
  input  logic [DATA_WIDTH/8-1:0] wr_strb_i
);

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  // Non-blocking update gives read-before-write on a shared edge.
  always_ff @(posedge clk_i) begin
    if (rd_en_i) begin
      rd_data_o <= mem[rd_idx_i];
    end
    if (wr_en_i) begin
      for (int i = 0; i < DATA_WIDTH / 8; i++) begin
        if (wr_strb_i[i]) begin
          mem[wr_idx_i][8*i +: 8] <= wr_data_i[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/axil_sram.sv
// AXI4-Lite responder backed by a private on-chip SRAM, with configurable
// read and write latency to exercise initiator stall paths.
module axil_sram
  import axil_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned           DEPTH_WORDS = 4096,
  parameter int unsigned           RD_LAT      = 1,
  parameter int unsigned           WR_LAT      = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready
);

  localparam int unsigned StrbW = DATA_WIDTH / 8;
  localparam int unsigned IdxW  = $clog2(DEPTH_WORDS);
  // One bit wider than the address so the window end cannot wrap.
  localparam logic [ADDR_WIDTH:0] EndAddr =
    {1'b0, BASE_ADDR} + (ADDR_WIDTH+1)'(4 * DEPTH_WORDS);

  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} >= {1'b0, BASE_ADDR}) && ({1'b0, a} < EndAddr);
  endfunction

  function automatic logic [IdxW-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
    return IdxW'((a - BASE_ADDR) >> 2);
  endfunction

  // Read channel
  rd_state_t             rd_state_q, rd_state_d;
  logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
  logic [LAT_W-1:0]      rd_cnt_q, rd_cnt_d;
  logic                  rd_err_q, rd_err_d;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_fire;
  logic                  mem_rd_en;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  always_comb begin
    rd_state_d = rd_state_q;
    ar_addr_d  = ar_addr_q;
    rd_cnt_d   = rd_cnt_q;
    rd_err_d   = rd_err_q;
    rd_addr    = ar_addr_q;
    rd_fire    = 1'b0;
    mem_rd_en  = 1'b0;
    unique case (rd_state_q)
      R_IDLE: begin
        if (arvalid) begin
          ar_addr_d = araddr;
          rd_addr   = araddr;
          rd_cnt_d  = LAT_W'(RD_LAT - 1);
          if (RD_LAT == 1) begin
            rd_fire    = 1'b1;
            rd_state_d = R_RESP;
          end else begin
            rd_state_d = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        rd_cnt_d = rd_cnt_q - LAT_W'(1);
        if (rd_cnt_d == '0) begin
          rd_fire    = 1'b1;
          rd_state_d = R_RESP;
        end
      end
      R_RESP: begin
        if (rready) begin
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
    if (rd_fire) begin
      mem_rd_en = addr_ok(rd_addr);
      rd_err_d  = !addr_ok(rd_addr);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_state_q <= R_IDLE;
      ar_addr_q  <= '0;
      rd_cnt_q   <= '0;
      rd_err_q   <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      ar_addr_q  <= ar_addr_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_err_q   <= rd_err_d;
    end
  end

  assign arready = (rd_state_q == R_IDLE);
  assign rvalid  = (rd_state_q == R_RESP);
  assign rresp   = rd_err_q ? RESP_SLVERR : RESP_OKAY;
  // The SRAM output register is not reset, so rdata is forced to zero outside
  // a good response.
  assign rdata   = (rvalid && !rd_err_q) ? mem_rd_data : '0;

  // Write channel
  wr_state_t             wr_state_q, wr_state_d;
  logic                  aw_held_q, aw_held_d;
  logic                  w_held_q, w_held_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [StrbW-1:0]      w_strb_q, w_strb_d;
  logic [LAT_W-1:0]      wr_cnt_q, wr_cnt_d;
  logic                  wr_err_q, wr_err_d;
  logic                  wr_fire;
  logic                  mem_wr_en;

  assign awready = (wr_state_q == W_IDLE) && !aw_held_q;
  assign wready  = (wr_state_q == W_IDLE) && !w_held_q;

  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    aw_addr_d  = aw_addr_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    wr_cnt_d   = wr_cnt_q;
    wr_err_d   = wr_err_q;
    wr_fire    = 1'b0;
    mem_wr_en  = 1'b0;
    unique case (wr_state_q)
      W_IDLE: begin
        if (aw_held_q && w_held_q) begin
          wr_cnt_d = LAT_W'(WR_LAT - 1);
          if (WR_LAT == 1) begin
            wr_fire    = 1'b1;
            wr_state_d = B_RESP;
          end else begin
            wr_state_d = W_WAIT;
          end
        end
        if (awready && awvalid) begin
          aw_held_d = 1'b1;
          aw_addr_d = awaddr;
        end
        if (wready && wvalid) begin
          w_held_d = 1'b1;
          w_data_d = wdata;
          w_strb_d = wstrb;
        end
      end
      W_WAIT: begin
        wr_cnt_d = wr_cnt_q - LAT_W'(1);
        if (wr_cnt_d == '0) begin
          wr_fire    = 1'b1;
          wr_state_d = B_RESP;
        end
      end
      B_RESP: begin
        if (bready) begin
          wr_state_d = W_IDLE;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
    if (wr_fire) begin
      mem_wr_en = addr_ok(aw_addr_q);
      wr_err_d  = !addr_ok(aw_addr_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_state_q <= W_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      wr_cnt_q   <= '0;
      wr_err_q   <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      aw_addr_q  <= aw_addr_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      wr_cnt_q   <= wr_cnt_d;
      wr_err_q   <= wr_err_d;
    end
  end

  assign bvalid = (wr_state_q == B_RESP);
  assign bresp  = wr_err_q ? RESP_SLVERR : RESP_OKAY;

  axil_sram_mem #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .DATA_WIDTH  (DATA_WIDTH),
    .IDX_W       (IdxW)
  ) u_mem (
    .clk_i     (clk),
    .rd_en_i   (mem_rd_en),
    .rd_idx_i  (addr_idx(rd_addr)),
    .rd_data_o (mem_rd_data),
    .wr_en_i   (mem_wr_en),
    .wr_idx_i  (addr_idx(aw_addr_q)),
    .wr_data_i (w_data_q),
    .wr_strb_i (w_strb_q)
  );

endmodule

// File: tb/tb_axil_sram.sv
// Bench for axil_sram: directed transactions with literal expectations plus
// concurrent random traffic, all checked every cycle against a transaction model.
module tb_axil_sram;

  localparam int unsigned RdLat = 3;
  localparam int unsigned WrLat = 2;
  localparam int unsigned Depth = 256;
  localparam logic [31:0] Base  = 32'h8000_0000;

  logic        clk, rst;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0]  rresp, bresp;
  logic [3:0]  wstrb;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  axil_sram #(
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (32),
    .BASE_ADDR   (Base),
    .DEPTH_WORDS (Depth),
    .RD_LAT      (RdLat),
    .WR_LAT      (WrLat)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .araddr  (araddr),
    .arvalid (arvalid),
    .arready (arready),
    .rdata   (rdata),
    .rresp   (rresp),
    .rvalid  (rvalid),
    .rready  (rready),
    .awaddr  (awaddr),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wvalid  (wvalid),
    .wready  (wready),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500_000;
    $display("FAIL watchdog: run did not finish by cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tmo(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL timeout %s: got no response, expected one (cycle %0d)", name, cyc);
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mem_m   [Depth];
  logic [3:0]  known_m [Depth];
  bit          model_init = 0;
  bit          rd_busy, aw_held, w_held, wr_sched, exp_rv, exp_bv;
  int          rd_due, b_due;
  logic [31:0] rd_addr_m, aw_addr_m, w_data_m, rd_data_e, rd_mask_e;
  logic [3:0]  w_strb_m;
  logic [1:0]  rd_resp_e;

  function automatic bit m_in_range(input logic [31:0] a);
    longint off;
    off = longint'(a) - longint'(Base);
    return (off >= 0) && (off < longint'(4 * Depth));
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((longint'(a) - longint'(Base)) / 4);
  endfunction

  always @(negedge clk) begin
    if (!model_init) begin
      for (int i = 0; i < int'(Depth); i++) known_m[i] = 4'h0;
      model_init = 1;
    end
    if (!rst) begin
      chk("rvalid_in_reset", 32'(rvalid), 32'(0));
      chk("bvalid_in_reset", 32'(bvalid), 32'(0));
      rd_busy  = 0;
      aw_held  = 0;
      w_held   = 0;
      wr_sched = 0;
    end else begin
      exp_rv = rd_busy && (cyc >= rd_due);
      exp_bv = wr_sched && (cyc >= b_due);
      chk("arready", 32'(arready), 32'(!rd_busy));
      chk("awready", 32'(awready), 32'(!aw_held));
      chk("wready", 32'(wready), 32'(!w_held));
      chk("rvalid", 32'(rvalid), 32'(exp_rv));
      chk("bvalid", 32'(bvalid), 32'(exp_bv));
      if (exp_rv) begin
        chk("rresp", 32'(rresp), 32'(rd_resp_e));
        chk("rdata", rdata & rd_mask_e, rd_data_e & rd_mask_e);
      end
      if (exp_bv) chk("bresp", 32'(bresp), m_in_range(aw_addr_m) ? 32'(0) : 32'(2));
      // Advance: read side. The read edge ends cycle rd_due-1.
      if (!rd_busy && arvalid) begin
        rd_busy   = 1;
        rd_addr_m = araddr;
        rd_due    = cyc + int'(RdLat);
      end
      if (rd_busy && cyc == rd_due - 1) begin
        if (m_in_range(rd_addr_m)) begin
          rd_data_e = mem_m[m_idx(rd_addr_m)];
          for (int b = 0; b < 4; b++)
            rd_mask_e[8*b +: 8] = {8{known_m[m_idx(rd_addr_m)][b]}};
          rd_resp_e = 2'b00;
        end else begin
          rd_data_e = 32'h0;
          rd_mask_e = 32'hFFFF_FFFF;
          rd_resp_e = 2'b10;
        end
      end
      if (exp_rv && rready) rd_busy = 0;
      // Advance: write side. Commit edge ends cycle b_due-1, after the read above.
      if (aw_held && w_held && !wr_sched) begin
        wr_sched = 1;
        b_due    = cyc + int'(WrLat);
      end
      if (!aw_held && awvalid) begin
        aw_held   = 1;
        aw_addr_m = awaddr;
      end
      if (!w_held && wvalid) begin
        w_held   = 1;
        w_data_m = wdata;
        w_strb_m = wstrb;
      end
      if (wr_sched && cyc == b_due - 1 && m_in_range(aw_addr_m)) begin
        for (int b = 0; b < 4; b++)
          if (w_strb_m[b]) mem_m[m_idx(aw_addr_m)][8*b +: 8] = w_data_m[8*b +: 8];
        known_m[m_idx(aw_addr_m)] = known_m[m_idx(aw_addr_m)] | w_strb_m;
      end
      if (exp_bv && bready) begin
        aw_held  = 0;
        w_held   = 0;
        wr_sched = 0;
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic axi_read(input logic [31:0] addr, input int stall,
                          output logic [31:0] data, output logic [1:0] resp, output int lat);
    int h;
    bit ok;
    h = 0; data = '0; resp = '0; lat = -1;
    araddr = addr; arvalid = 1'b1; rready = (stall == 0);
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (arready) begin ok = 1; h = cyc; end
    end
    @(posedge clk); #1 arvalid = 1'b0;
    if (!ok) begin tmo("ar_handshake"); rready = 1'b0; return; end
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (rvalid) begin ok = 1; lat = cyc - h; end
    end
    if (!ok) begin tmo("rvalid"); rready = 1'b0; return; end
    if (stall > 0) begin
      repeat (stall) @(posedge clk);
      #1 rready = 1'b1;
      @(negedge clk);
    end
    data = rdata; resp = rresp;
    @(posedge clk); #1 rready = 1'b0;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly,
                           input int stall, output logic [1:0] resp, output int lat);
    int h_aw, h_w, hb;
    bit ok;
    h_aw = 0; h_w = 0; resp = '0; lat = -1;
    bready = (stall == 0);
    fork
      begin : aw_ch
        bit ok_a;
        for (int i = 0; i < aw_dly; i++) begin @(posedge clk); #1; end
        awaddr = addr; awvalid = 1'b1; ok_a = 0;
        for (int i = 0; i < 100 && !ok_a; i++) begin
          @(negedge clk);
          if (awready) begin ok_a = 1; h_aw = cyc; end
        end
        @(posedge clk); #1 awvalid = 1'b0;
        if (!ok_a) tmo("aw_handshake");
      end
      begin : w_ch
        bit ok_w;
        for (int i = 0; i < w_dly; i++) begin @(posedge clk); #1; end
        wdata = data; wstrb = strb; wvalid = 1'b1; ok_w = 0;
        for (int i = 0; i < 100 && !ok_w; i++) begin
          @(negedge clk);
          if (wready) begin ok_w = 1; h_w = cyc; end
        end
        @(posedge clk); #1 wvalid = 1'b0;
        if (!ok_w) tmo("w_handshake");
      end
    join
    hb = (h_aw > h_w) ? h_aw : h_w;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (bvalid) begin ok = 1; lat = cyc - hb; end
    end
    if (!ok) begin tmo("bvalid"); bready = 1'b0; return; end
    if (stall > 0) begin
      repeat (stall) @(posedge clk);
      #1 bready = 1'b1;
      @(negedge clk);
    end
    resp = bresp;
    @(posedge clk); #1 bready = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned sel;
    sel = $urandom_range(0, 9);
    if (sel == 0) return Base - 32'(4 * $urandom_range(1, 2));
    if (sel == 1) return Base + 32'(4 * Depth) + 32'(4 * $urandom_range(0, 1));
    return Base + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] d;
    logic [1:0]  r, r2;
    int          l, l2;
    bit          ok;
    rst = 1'b0; arvalid = 1'b0; araddr = '0; rready = 1'b0;
    awvalid = 1'b0; awaddr = '0; wvalid = 1'b0; wdata = '0; wstrb = '0; bready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("reset_arready", 32'(arready), 32'(1));
    chk("reset_awready", 32'(awready), 32'(1));
    chk("reset_wready", 32'(wready), 32'(1));
    chk("reset_rvalid", 32'(rvalid), 32'(0));
    chk("reset_bvalid", 32'(bvalid), 32'(0));
    @(posedge clk); #1;

    // Basic write and stalled readback
    axi_write(Base + 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, r, l);
    chk("wr_bresp", 32'(r), 32'(0));
    chk("wr_latency", 32'(l), WrLat + 1);
    axi_read(Base + 32'h10, 4, d, r, l);
    chk("rd_data", d, 32'hDEAD_BEEF);
    chk("rd_resp", 32'(r), 32'(0));
    chk("rd_latency", 32'(l), RdLat);

    // Byte strobes
    axi_write(Base + 32'h20, 32'h1122_3344, 4'hF, 0, 0, 1, r, l);
    axi_write(Base + 32'h20, 32'hAABB_CCDD, 4'b0101, 0, 0, 0, r, l);
    axi_read(Base + 32'h20, 0, d, r, l);
    chk("strobe_merge", d, 32'h11BB_33DD);

    // Channel ordering: W first, AW first, same cycle
    axi_write(Base + 32'h40, 32'hA0A0_0001, 4'hF, 2, 0, 0, r, l);
    chk("w_first_bresp", 32'(r), 32'(0));
    chk("w_first_latency", 32'(l), WrLat + 1);
    axi_write(Base + 32'h44, 32'hB0B0_0002, 4'hF, 0, 2, 2, r, l);
    chk("aw_first_bresp", 32'(r), 32'(0));
    axi_write(Base + 32'h48, 32'hC0C0_0003, 4'hF, 0, 0, 0, r, l);
    axi_read(Base + 32'h40, 1, d, r, l);
    chk("w_first_data", d, 32'hA0A0_0001);
    axi_read(Base + 32'h44, 0, d, r, l);
    chk("aw_first_data", d, 32'hB0B0_0002);
    axi_read(Base + 32'h48, 0, d, r, l);
    chk("same_cycle_data", d, 32'hC0C0_0003);

    // Out of range: words 0 and Depth-1 are the alias targets of the bad addresses
    axi_write(Base, 32'h0BAD_F00D, 4'hF, 0, 0, 0, r, l);
    axi_write(Base + 32'(4 * (Depth - 1)), 32'h600D_CAFE, 4'hF, 0, 0, 0, r, l);
    axi_read(32'h7FFF_FFFC, 0, d, r, l);
    chk("oor_low_rresp", 32'(r), 32'(2));
    chk("oor_low_rdata", d, 32'h0);
    axi_read(Base + 32'(4 * Depth), 0, d, r, l);
    chk("oor_high_rresp", 32'(r), 32'(2));
    chk("oor_high_rdata", d, 32'h0);
    axi_write(32'h7FFF_FFFC, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, r, l);
    chk("oor_low_bresp", 32'(r), 32'(2));
    axi_write(Base + 32'(4 * Depth), 32'hFFFF_FFFF, 4'hF, 1, 0, 0, r, l);
    chk("oor_high_bresp", 32'(r), 32'(2));
    axi_read(Base, 0, d, r, l);
    chk("oor_word0_kept", d, 32'h0BAD_F00D);
    axi_read(Base + 32'(4 * (Depth - 1)), 0, d, r, l);
    chk("oor_wordlast_kept", d, 32'h600D_CAFE);

    // Read edge and commit edge coincide on one word
    axi_write(Base + 32'h30, 32'h0102_0304, 4'hF, 0, 0, 0, r, l);
    fork
      axi_write(Base + 32'h30, 32'h5566_7788, 4'hF, 0, 0, 0, r2, l2);
      axi_read(Base + 32'h30, 0, d, r, l);
    join
    chk("hazard_old_data", d, 32'h0102_0304);
    axi_read(Base + 32'h30, 0, d, r, l);
    chk("hazard_new_data", d, 32'h5566_7788);

    // Reset while the read is in R_WAIT
    araddr = Base + 32'h10; arvalid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 arvalid = 1'b0;
    rst = 1'b0;
    #1 chk("rst_rwait_rvalid", 32'(rvalid), 32'(0));
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_rwait_arready", 32'(arready), 32'(1));
    repeat (4) @(negedge clk);
    chk("rst_rwait_no_resp", 32'(rvalid), 32'(0));
    @(posedge clk); #1;

    // Reset while a response is being held
    araddr = Base + 32'h10; arvalid = 1'b1; rready = 1'b0;
    @(negedge clk);
    @(posedge clk); #1 arvalid = 1'b0;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (rvalid) ok = 1;
    end
    if (!ok) tmo("rvalid_before_reset");
    @(posedge clk); #1 rst = 1'b0;
    #1 chk("rst_rresp_rvalid", 32'(rvalid), 32'(0));
    chk("rst_rresp_rdata", rdata, 32'h0);
    @(posedge clk); #1 rst = 1'b1;
    axi_read(Base + 32'h10, 0, d, r, l);
    chk("mem_survives_reset", d, 32'hDEAD_BEEF);

    // Concurrent random traffic
    fork
      begin : rd_loop
        logic [31:0] rd_d;
        logic [1:0]  rd_r;
        int          rd_l;
        for (int n = 0; n < 60; n++) begin
          axi_read(rand_addr(), int'($urandom_range(0, 3)), rd_d, rd_r, rd_l);
          chk("rand_rd_latency", 32'(rd_l), RdLat);
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
      end
      begin : wr_loop
        logic [1:0] wr_r;
        int         wr_l;
        for (int n = 0; n < 60; n++) begin
          axi_write(rand_addr(), $urandom, 4'($urandom_range(0, 15)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), wr_r, wr_l);
          chk("rand_wr_latency", 32'(wr_l), WrLat + 1);
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
      end
    join

    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axil_sram.md
Name: axil_sram

Overview:
AXI4-Lite responder that backs the IFU instruction-fetch port and the LSU data port with a word-organised on-chip SRAM. It terminates the AR/R/AW/W/B channels these initiators drive. Read and write latency are configurable so the pipeline's valid/ready stall paths can be exercised. One instance is placed per initiator; the two instances do not share storage.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, data width; fixed at 32, byte lanes = 4
BASE_ADDR, 32'h8000_0000, byte address of word 0
DEPTH_WORDS, 4096, number of 32-bit words; power of two
RD_LAT, 1, cycles from AR handshake to rvalid; legal range 1..15
WR_LAT, 1, cycles from the cycle both AW and W are held to bvalid; legal range 1..15

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low (asserted when 0), one clock domain
araddr  input  32  read byte address
arvalid  input  1  read address valid
arready  output  1  read address ready
rdata  output  32  read data
rresp  output  2  read response: 00 OKAY, 10 SLVERR
rvalid  output  1  read data valid
rready  input  1  read data ready
awaddr  input  32  write byte address
awvalid  input  1  write address valid
awready  output  1  write address ready
wdata  input  32  write data
wstrb  input  4  byte enables
wvalid  input  1  write data valid
wready  output  1  write data ready
bresp  output  2  write response: 00 OKAY, 10 SLVERR
bvalid  output  1  write response valid
bready  input  1  write response ready

Behaviour:
- Reset (rst=0, asynchronous):
  - Read FSM goes to R_IDLE; write FSM goes to W_IDLE.
  - rvalid=0, bvalid=0, rdata=0, rresp=00, bresp=00.
  - arready=1 and awready=wready=1 once rst=1.
  - SRAM contents are not reset.
  - Reset mid-transaction drops the transaction; no memory write occurs unless its commit edge has already passed.
- Address decode:
  - index = (addr - BASE_ADDR) >> 2; addr[1:0] is ignored.
  - In range iff BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH_WORDS; the comparison is unsigned and has no wrap-around.
  - Out of range: read returns rdata=0 with rresp=10; write is dropped with bresp=10.
- Read FSM (R_IDLE -> R_WAIT -> R_RESP):
  - arready = (state==R_IDLE).
  - AR handshake at cycle T latches the address and loads the counter with RD_LAT-1.
  - R_WAIT decrements the counter. When it reaches 0, SRAM is read on that edge; rvalid=1 from cycle T+RD_LAT.
  - With RD_LAT=1, the FSM goes straight from R_IDLE to R_RESP.
  - In R_RESP, rdata and rresp are held stable until rready=1.
  - The R handshake returns the FSM to R_IDLE the next cycle, so there is one bubble between back-to-back reads.
- Write FSM (W_IDLE -> W_WAIT -> B_RESP):
  - In W_IDLE, AW and W are captured independently, in either order or in the same cycle.
  - awready drops after AW is captured; wready drops after W is captured.
  - At the first cycle T where both are held, the counter loads WR_LAT-1.
  - The SRAM write commits on the edge that raises bvalid, at cycle T+WR_LAT.
  - Only the byte lanes with wstrb[i]=1 are written. wstrb=0000 is OKAY and writes nothing.
  - bvalid and bresp are held until bready=1, then the FSM returns to W_IDLE.
- Read and write channels run concurrently:
  - If the SRAM read and write hit the same word on the same edge, the read returns the pre-write data.
  - A read whose AR handshake follows a B handshake observes the new data.
- No outstanding-transaction queueing: at most one read and one write are in flight.

Decomposition:
- Package axil_pkg holds:
  - resp_t codes RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
  - Enums rd_state_t {R_IDLE,R_WAIT,R_RESP} and wr_state_t {W_IDLE,W_WAIT,B_RESP}.
  - Localparam LAT_W=4.
- Sub-module axil_sram_mem: DEPTH_WORDS x 32 array with one synchronous read port, one synchronous byte-masked write port, and read-before-write semantics.
- Top-level axil_sram holds the two FSMs, the latency counters and the address decode.

Test Plan:
- Reset then write: rst low 3 cycles then high. Check arready=awready=wready=1 and rvalid=bvalid=0. Write 0xDEADBEEF, wstrb=1111, to 0x8000_0010. Expect bresp=00, bvalid at T+WR_LAT.
- Readback with stall: RD_LAT=3, read 0x8000_0010 with rready held 0 for 4 cycles. Expect rvalid at T+3, rdata=0xDEADBEEF stable through the stall, rresp=00. Expect arready=0 until the cycle after the R handshake.
- Byte strobes: word 0x8000_0020 holds 0x11223344. Write wdata=0xAABBCCDD, wstrb=0101. Readback 0x11BB33DD.
- Channel ordering: W presented 2 cycles before AW, then the other order. Expect one B response per pair and correct data in both cases. Repeat with AW and W in the same cycle.
- Out of range: read 0x7FFF_FFFC and 0x8000_0000+4*DEPTH_WORDS; expect rresp=10, rdata=0. Write to the same addresses; expect bresp=10 and memory unchanged.
- Hazard and reset: a write commit and a read of the same word on the same edge return the old data. Drop rst during R_WAIT; expect rvalid=0 immediately and arready=1 after release.
